regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2: number of write-back requesters (2..8).
REQ-002 The block SHALL have parameter AWIDTH, default 5: register address width.
REQ-003 The block SHALL have parameter DWIDTH, default 32: register data width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the only clock, rising edge.
REQ-006 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-007 Port req_valid, input, NREQ bits: per-requester write-back request.
REQ-008 Port req_addr, input, NREQ x AWIDTH: per-requester destination register.
REQ-009 Port req_data, input, NREQ x DWIDTH: per-requester write data.
REQ-010 Port req_ready, output, NREQ bits: per-requester accept, combinational.
REQ-011 Port flush, input, 1 bit: block new grants while high.
REQ-012 Port wen, output, 1 bit: register-bank write enable, registered.
REQ-013 Port waddr, output, AWIDTH bits: register-bank write address, registered.
REQ-014 Port wdata, output, DWIDTH bits: register-bank write data, registered.
REQ-015 Port raddr1 / raddr2, input, AWIDTH bits each: register-bank read addresses, observed for forwarding.
REQ-016 Port rdata1_in / rdata2_in, input, DWIDTH bits each: register-bank read data.
REQ-017 Port rdata1_out / rdata2_out, output, DWIDTH bits each: read data after optional forwarding.

Function
REQ-018 A transfer SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high; it completes in that cycle.
REQ-019 At most one req_ready bit SHALL be high in any cycle.
REQ-020 req_ready SHALL be all zero while rst or flush is high, or while req_valid is zero.
REQ-021 Otherwise req_ready SHALL be one-hot, selecting the first valid requester found by searching upward from pointer rr_ptr and wrapping from NREQ-1 to 0.
REQ-022 On a transfer by requester i, rr_ptr SHALL become (i+1) mod NREQ; without a transfer, rr_ptr SHALL hold.
REQ-023 A transfer with req_addr != 0 at edge N SHALL drive wen=1 for exactly the cycle after edge N, with the accepted waddr and wdata; latency is 1.
REQ-024 A transfer with req_addr == 0 SHALL complete the handshake, leave wen=0, and leave waddr and wdata unchanged.
REQ-025 Without a transfer, wen SHALL be 0 in the next cycle, and waddr and wdata SHALL hold their values.
REQ-026 Back-to-back transfers SHALL be sustained: one per cycle, no bubbles.
REQ-027 A flush asserted in the same cycle as a valid request SHALL block the grant; a write already registered (wen=1) SHALL still complete.
REQ-028 Requester inputs MAY change only after a transfer or while that requester is deasserted; the block SHALL NOT store unaccepted requests.

Reset
REQ-029 While rst is sampled high: wen=0, waddr=0, wdata=0, rr_ptr=0, req_ready=0.
REQ-030 A reset asserted mid-stream SHALL drop the pending registered write (wen=0 on the next cycle).
REQ-031 The first grant after reset SHALL go to the lowest-indexed valid requester.

Configuration
REQ-032 Macro REGFILE_WB_FWD_EN SHALL enable write-back forwarding.
REQ-033 With REGFILE_WB_FWD_EN defined: rdataK_out SHALL equal wdata when wen=1, waddr==raddrK and raddrK != 0; otherwise it SHALL equal rdataK_in (K = 1, 2).
REQ-034 Without REGFILE_WB_FWD_EN: rdataK_out SHALL equal rdataK_in, and the ports SHALL still exist.

Structure
REQ-035 Package regfile_arb_pkg SHALL hold the default NREQ/AWIDTH/DWIDTH constants and the typedef for the requester index (width $clog2(NREQ)).
REQ-036 Sub-module rr_arbiter SHALL hold the round-robin grant logic and rr_ptr; regfile_wb_arbiter SHALL hold the output register and the forwarding mux.

Verification
REQ-037 After reset, req_valid=2'b11 held -> grants 0,1,0,1 on consecutive cycles; wen=1 every cycle after the first.
REQ-038 Requester 0 sends addr 5, data 0xDEADBEEF -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF; the following cycle wen=0.
REQ-039 Requester 1 sends addr 0, data 0x1234 -> req_ready[1]=1, wen stays 0, waddr and wdata unchanged.
REQ-040 flush=1 with req_valid=2'b01 -> req_ready=0 and rr_ptr unchanged; after flush=0 -> grant 0 in the same cycle.
REQ-041 rst=1 in the cycle after a transfer -> wen=0 next cycle; afterwards req_valid=2'b10 -> grant 1, rr_ptr=0.
REQ-042 With FWD_EN: wen=1, waddr=7, wdata=0xA5, raddr1=7, raddr2=0 -> rdata1_out=0xA5, rdata2_out=rdata2_in; without FWD_EN -> rdata1_out=rdata1_in.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared default sizes and requester index type for the write-back arbiter
package regfile_arb_pkg;
  localparam int NREQ_DEF = 2;
  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 32;
  typedef logic [$clog2(NREQ_DEF)-1:0] req_idx_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester-side write-back bus (valid/addr/data in, ready out)
interface regfile_wb_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0][AWIDTH-1:0] req_addr;
  logic [NREQ-1:0][DWIDTH-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  modport master(output req_valid, req_addr, req_data, input req_ready);
  modport slave(input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with rotating pointer rr_ptr, blocked by rst/flush
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] ready,
  output logic [IW-1:0]   gidx
);
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && valid[j]) begin
        found = 1'b1;
        gidx = j;
      end
    end
    ready = (found && !rst && !flush) ? NREQ'(1) << gidx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (|ready) rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates write-backs into one registered bank write port.
// Define REGFILE_WB_FWD_EN to forward the pending write onto the read data outputs.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  regfile_wb_arbiter_if.slave bus,
  output logic              wen,
  output logic [AWIDTH-1:0] waddr,
  output logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr1,
  input  logic [AWIDTH-1:0] raddr2,
  input  logic [DWIDTH-1:0] rdata1_in,
  input  logic [DWIDTH-1:0] rdata2_in,
  output logic [DWIDTH-1:0] rdata1_out,
  output logic [DWIDTH-1:0] rdata2_out
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] gidx;
  logic [AWIDTH-1:0] a;
  logic [DWIDTH-1:0] d;
  logic commit;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .valid(bus.req_valid),
    .ready(bus.req_ready),
    .gidx(gidx)
  );
  assign a = bus.req_addr[gidx];
  assign d = bus.req_data[gidx];
  // writes to r0 still handshake but never reach the bank
  assign commit = |bus.req_ready && a != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      wen <= commit;
      if (commit) begin
        waddr <= a;
        wdata <= d;
      end
    end
  end
`ifdef REGFILE_WB_FWD_EN
  assign rdata1_out = (wen && waddr == raddr1 && raddr1 != '0) ? wdata : rdata1_in;
  assign rdata2_out = (wen && waddr == raddr2 && raddr2 != '0) ? wdata : rdata2_in;
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign rdata1_out = rdata1_in;
  assign rdata2_out = rdata2_in;
`endif
endmodule
